reg_file_sb: RTL and testbench

- Parametrised 2-read / 1-write CPU register file. Successor to the fixed 32x32 dual-edge register file.
- Single-edge operation: all writes and reads on posedge clk. Reads are registered and include write-to-read forwarding.
- Adds a per-register pending-write scoreboard, so the pipeline can detect and stall on RAW hazards from multi-cycle producers such as loads and the multiplier.
- Sits between the decode stage (reads, pend_set) and the writeback stage (we).

---
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2-read/1-write register file with write forwarding and pending-write scoreboard
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              any_pend
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] NUM_REGS_C = CW'(NUM_REGS);

  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Unimplemented entries are never written, so they stay 0 and read back as 0.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic              rs_busy_q, rs_busy_d, rt_busy_q, rt_busy_d;
  logic              clr, set, inc, dec;

  always_comb begin
    clr        = we && is_legal(wr_addr);
    set        = pend_set && is_legal(pend_addr);
    mem_d      = mem_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    rs_busy_d  = rs_busy_q;
    rt_busy_d  = rt_busy_q;

    if (clr) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // A newly issued producer outranks a retiring one on the same register.
    if (set) begin
      pend_d[pend_addr] = 1'b1;
    end

    inc = set && !pend_q[pend_addr];
    dec = clr && pend_q[wr_addr] && !(set && (pend_addr == wr_addr));
    if (inc && !dec) begin
      pend_cnt_d = pend_cnt_q + CW'(1);
    end else if (dec && !inc) begin
      pend_cnt_d = pend_cnt_q - CW'(1);
    end

    // Sampling next-state gives forwarding and busy aligned to the same cycle.
    if (rd_en) begin
      rs_data_d = is_legal(rs_addr) ? mem_d[rs_addr] : '0;
      rt_data_d = is_legal(rt_addr) ? mem_d[rt_addr] : '0;
      rs_busy_d = is_legal(rs_addr) && pend_d[rs_addr];
      rt_busy_d = is_legal(rt_addr) && pend_d[rt_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rs_busy_q  <= 1'b0;
      rt_busy_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      rs_busy_q  <= rs_busy_d;
      rt_busy_q  <= rt_busy_d;
    end
  end

  assign rs_data  = rs_data_q;
  assign rt_data  = rt_data_q;
  assign rs_busy  = rs_busy_q;
  assign rt_busy  = rt_busy_q;
  assign pend_cnt = pend_cnt_q;
  assign any_pend = (pend_cnt_q != '0);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed scoreboard bench for reg_file_sb (default and 16-register variant)
module tb_reg_file_sb;

  logic clk;
  logic rst_n;

  logic        a_rd_en, a_we, a_pend_set;
  logic [4:0]  a_rs_addr, a_rt_addr, a_wr_addr, a_pend_addr;
  logic [31:0] a_wr_data, a_rs_data, a_rt_data;
  logic        a_rs_busy, a_rt_busy, a_any_pend;
  logic [5:0]  a_pend_cnt;

  logic        b_rd_en, b_we, b_pend_set;
  logic [4:0]  b_rs_addr, b_rt_addr, b_wr_addr, b_pend_addr;
  logic [31:0] b_wr_data, b_rs_data, b_rt_data;
  logic        b_rs_busy, b_rt_busy, b_any_pend;
  logic [5:0]  b_pend_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          sel_b;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        rs_b;
    logic        rt_b;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  reg_file_sb dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(a_rd_en), .rs_addr(a_rs_addr), .rt_addr(a_rt_addr),
    .rs_data(a_rs_data), .rt_data(a_rt_data), .rs_busy(a_rs_busy), .rt_busy(a_rt_busy),
    .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .pend_set(a_pend_set),
    .pend_addr(a_pend_addr), .pend_cnt(a_pend_cnt), .any_pend(a_any_pend)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(b_rd_en), .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
    .rs_data(b_rs_data), .rt_data(b_rt_data), .rs_busy(b_rs_busy), .rt_busy(b_rt_busy),
    .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .pend_set(b_pend_set),
    .pend_addr(b_pend_addr), .pend_cnt(b_pend_cnt), .any_pend(b_any_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    a_rd_en = 0; a_we = 0; a_pend_set = 0;
    a_rs_addr = 0; a_rt_addr = 0; a_wr_addr = 0; a_pend_addr = 0; a_wr_data = 0;
    b_rd_en = 0; b_we = 0; b_pend_set = 0;
    b_rs_addr = 0; b_rt_addr = 0; b_wr_addr = 0; b_pend_addr = 0; b_wr_data = 0;
  endtask

  // Drive one cycle on the selected DUT, push the expectation, pop and compare after the edge.
  task automatic step(input string tag, input bit sel_b,
                      input logic rd, input logic [4:0] rs, input logic [4:0] rt,
                      input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ps, input logic [4:0] pa,
                      input logic [31:0] e_rs, input logic [31:0] e_rt,
                      input logic e_rsb, input logic e_rtb, input logic [5:0] e_cnt);
    exp_t e;
    idle_all();
    if (!sel_b) begin
      a_rd_en = rd; a_rs_addr = rs; a_rt_addr = rt; a_we = w; a_wr_addr = wa;
      a_wr_data = wd; a_pend_set = ps; a_pend_addr = pa;
    end else begin
      b_rd_en = rd; b_rs_addr = rs; b_rt_addr = rt; b_we = w; b_wr_addr = wa;
      b_wr_data = wd; b_pend_set = ps; b_pend_addr = pa;
    end
    e.tag = tag; e.sel_b = sel_b; e.rs_d = e_rs; e.rt_d = e_rt;
    e.rs_b = e_rsb; e.rt_b = e_rtb; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle_all();
    e = exp_q.pop_front();
    if (!e.sel_b) begin
      chk({e.tag, ".rs_data"}, a_rs_data, e.rs_d);
      chk({e.tag, ".rt_data"}, a_rt_data, e.rt_d);
      chk({e.tag, ".rs_busy"}, 32'(a_rs_busy), 32'(e.rs_b));
      chk({e.tag, ".rt_busy"}, 32'(a_rt_busy), 32'(e.rt_b));
      chk({e.tag, ".pend_cnt"}, 32'(a_pend_cnt), 32'(e.cnt));
      chk({e.tag, ".any_pend"}, 32'(a_any_pend), 32'(e.cnt != 0));
    end else begin
      chk({e.tag, ".rs_data"}, b_rs_data, e.rs_d);
      chk({e.tag, ".rt_data"}, b_rt_data, e.rt_d);
      chk({e.tag, ".rs_busy"}, 32'(b_rs_busy), 32'(e.rs_b));
      chk({e.tag, ".rt_busy"}, 32'(b_rt_busy), 32'(e.rt_b));
      chk({e.tag, ".pend_cnt"}, 32'(b_pend_cnt), 32'(e.cnt));
      chk({e.tag, ".any_pend"}, 32'(b_any_pend), 32'(e.cnt != 0));
    end
  endtask

  initial begin
    idle_all();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst0.a_rs_data", a_rs_data, 32'h0);
    chk("rst0.a_pend_cnt", 32'(a_pend_cnt), 32'h0);
    chk("rst0.b_rt_data", b_rt_data, 32'h0);
    #9 rst_n = 1'b1;

    // Reset in the middle of operation
    step("pre_rst", 0, 1, 5, 7, 1, 5, 32'h1234, 1, 7, 32'h1234, 32'h0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.rs_data", a_rs_data, 32'h0);
    chk("midrst.rt_busy", 32'(a_rt_busy), 32'h0);
    chk("midrst.pend_cnt", 32'(a_pend_cnt), 32'h0);
    chk("midrst.any_pend", 32'(a_any_pend), 32'h0);
    #1 rst_n = 1'b1;
    step("post_rst", 0, 1, 5, 7, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // Forwarding, then hold
    step("wr_r4", 0, 0, 0, 0, 1, 4, 32'h4444_4444, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step("fwd_r3", 0, 1, 3, 4, 1, 3, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 32'h4444_4444, 0, 0, 0);
    step("hold", 0, 0, 0, 0, 1, 3, 32'h1, 0, 0, 32'hDEAD_BEEF, 32'h4444_4444, 0, 0, 0);
    step("rd_r3", 0, 1, 3, 3, 0, 0, 0, 0, 0, 32'h1, 32'h1, 0, 0, 0);

    // Zero register
    step("zero_wr", 0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'h0, 32'h0, 0, 0, 0);
    step("zero_rd", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // Scoreboard lifecycle
    step("r8_set", 0, 1, 8, 8, 0, 0, 0, 1, 8, 32'h0, 32'h0, 1, 1, 1);
    step("r8_wb", 0, 1, 8, 8, 1, 8, 32'd77, 0, 0, 32'd77, 32'd77, 0, 0, 0);
    step("r8_rd", 0, 1, 8, 4, 0, 0, 0, 0, 0, 32'd77, 32'h4444_4444, 0, 0, 0);

    // Simultaneous set and clear
    step("r9_set", 0, 1, 9, 9, 0, 0, 0, 1, 9, 32'h0, 32'h0, 1, 1, 1);
    step("r9_setclr", 0, 1, 9, 9, 1, 9, 32'd5, 1, 9, 32'd5, 32'd5, 1, 1, 1);
    step("r9clr_r10set", 0, 1, 9, 10, 1, 9, 32'd6, 1, 10, 32'd6, 32'h0, 0, 1, 1);
    step("busy_hold", 0, 0, 0, 0, 1, 10, 32'd3, 0, 0, 32'd6, 32'h0, 0, 1, 0);
    step("re_pend", 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'd6, 32'h0, 0, 1, 1);
    step("re_pend2", 0, 1, 11, 11, 0, 0, 0, 1, 11, 32'h0, 32'h0, 1, 1, 1);

    // 16-register variant without a hardwired zero register
    step("b_r0_wr", 1, 1, 0, 0, 1, 0, 32'd42, 0, 0, 32'd42, 32'd42, 0, 0, 0);
    step("b_r0_rd", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'd42, 32'd42, 0, 0, 0);
    step("b_r20", 1, 1, 20, 0, 1, 20, 32'h99, 1, 20, 32'h0, 32'd42, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("b_set%0d", i), 1, 0, 0, 0, 0, 0, 0, 1, 5'(i),
           32'h0, 32'd42, 0, 0, 6'(i + 1));
    end
    step("b_full", 1, 1, 15, 20, 0, 0, 0, 1, 3, 32'h0, 32'h0, 1, 0, 16);
    step("b_clr0", 1, 1, 0, 3, 1, 0, 32'd7, 0, 0, 32'd7, 32'h0, 0, 1, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
